// File: rtl/img_preproc_pkg.sv
// Shared types for the image pre-processing stream.
//   mode_t  : per-frame pixel operation select
//   state_t : frame tracking FSM states
package img_preproc_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_PASS    = 2'd0,
    MODE_INVERT  = 2'd1,
    MODE_THRESH  = 2'd2,
    MODE_ADD_SAT = 2'd3
  } mode_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/img_preproc_lane.sv
// Combinational single-lane pixel operation.
//   mode    : operation (PASS / INVERT / THRESH / ADD_SAT)
//   param   : threshold or additive offset
//   pix_in  : input pixel
//   pix_out : processed pixel
module img_preproc_lane
  import img_preproc_pkg::*;
#(
  parameter int unsigned PIX_W = 8
) (
  input  mode_t            mode,
  input  logic [PIX_W-1:0] param,
  input  logic [PIX_W-1:0] pix_in,
  output logic [PIX_W-1:0] pix_out
);

  logic [PIX_W:0] sum;

  // Saturating add is evaluated one bit wider so the carry flags overflow.
  always_comb begin
    sum     = {1'b0, pix_in} + {1'b0, param};
    pix_out = pix_in;
    case (mode)
      MODE_PASS:    pix_out = pix_in;
      MODE_INVERT:  pix_out = ~pix_in;
      MODE_THRESH:  pix_out = (pix_in >= param) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
      MODE_ADD_SAT: pix_out = sum[PIX_W] ? {PIX_W{1'b1}} : sum[PIX_W-1:0];
      default:      pix_out = pix_in;
    endcase
  end

endmodule

// File: rtl/img_preproc_stream.sv
// Two-stage streaming pixel processor with per-frame mode/param latching.
//   clock, reset          : rising-edge clock, async active-high reset
//   in_data/in_valid      : input word, transfers when in_valid && !upstream_stall
//   upstream_stall        : block cannot accept this cycle
//   mode/param            : operation select, sampled at frame start
//   out_data/out_valid    : processed word
//   out_last              : final word of a frame
//   downstream_stall      : consumer not ready, output holds
//   busy                  : frame partially accepted
module img_preproc_stream
  import img_preproc_pkg::*;
#(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned LANES       = 4,
  parameter int unsigned FRAME_WORDS = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [PIX_W*LANES-1:0]   in_data,
  input  logic                     in_valid,
  output logic                     upstream_stall,
  input  logic [MODE_W-1:0]        mode,
  input  logic [PIX_W-1:0]         param,
  output logic [PIX_W*LANES-1:0]   out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     downstream_stall,
  output logic                     busy
);

  localparam int unsigned DATA_W = PIX_W * LANES;
  localparam int unsigned CNT_W  = (FRAME_WORDS > 2) ? $clog2(FRAME_WORDS) : 1;

  state_t            state;
  logic [CNT_W-1:0]  word_cnt;
  mode_t             frame_mode;
  logic [PIX_W-1:0]  frame_param;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s1_last;

  logic              s2_en;
  logic              s1_en;
  logic              accept;
  logic              last_tag;
  mode_t             eff_mode;
  logic [PIX_W-1:0]  eff_param;
  logic [DATA_W-1:0] lane_out;

  // Stage enables depend only on registered state and downstream_stall.
  always_comb begin
    s2_en          = !out_valid || !downstream_stall;
    s1_en          = !s1_valid || s2_en;
    upstream_stall = !s1_en;
    accept         = in_valid && s1_en;
    last_tag       = (state == ST_ACTIVE) && (word_cnt == CNT_W'(FRAME_WORDS - 1));
  end

  // First word of a frame uses live mode/param; later words use the latched copy.
  always_comb begin
    eff_mode  = frame_mode;
    eff_param = frame_param;
    if (state == ST_IDLE) begin
      eff_mode  = mode_t'(mode);
      eff_param = param;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    img_preproc_lane #(
      .PIX_W (PIX_W)
    ) u_lane (
      .mode    (eff_mode),
      .param   (eff_param),
      .pix_in  (in_data[i*PIX_W +: PIX_W]),
      .pix_out (lane_out[i*PIX_W +: PIX_W])
    );
  end

  // Frame tracking FSM; advances only on accepted words.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      word_cnt    <= '0;
      frame_mode  <= MODE_PASS;
      frame_param <= '0;
    end else if (accept) begin
      case (state)
        ST_IDLE: begin
          frame_mode  <= mode_t'(mode);
          frame_param <= param;
          word_cnt    <= CNT_W'(1);
          state       <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (last_tag) begin
            word_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            word_cnt <= word_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_ACTIVE);

  // S1: computed word plus its last tag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_last  <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= lane_out;
        s1_last <= last_tag;
      end
    end
  end

  // S2: output register, held while the consumer stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      out_data  <= s1_data;
      out_last  <= s1_last;
    end
  end

endmodule

// File: tb/tb_img_preproc_stream.sv
// Directed self-checking bench for img_preproc_stream (PIX_W=8, LANES=4, FRAME_WORDS=4).
module tb_img_preproc_stream;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        upstream_stall;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  param = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        downstream_stall = 1'b0;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  img_preproc_stream #(
    .PIX_W       (8),
    .LANES       (4),
    .FRAME_WORDS (4)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .upstream_stall   (upstream_stall),
    .mode             (mode),
    .param            (param),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_last         (out_last),
    .downstream_stall (downstream_stall),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    downstream_stall = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    vectors++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data got %h want 00000000", out_data); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last got %0b want 0", out_last); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
    vectors++; if (upstream_stall !== 1'b0) begin miscompares++; $display("FAIL reset_upstream_stall got %0b want 0", upstream_stall); end
  endtask

  task automatic test_pass_latency();
    do_reset();
    mode = 2'd0; in_data = 32'h11223344; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL pass_t1_valid got %0b want 0", out_valid); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL pass_busy got %0b want 1", busy); end
    tick();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL pass_t2_valid got %0b want 1", out_valid); end
    vectors++; if (out_data !== 32'h11223344) begin miscompares++; $display("FAIL pass_data got %h want 11223344", out_data); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL pass_last got %0b want 0", out_last); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL pass_t3_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_ops();
    logic [1:0]  op_mode [3] = '{2'd1, 2'd2, 2'd3};
    logic [7:0]  op_par  [3] = '{8'h00, 8'h80, 8'h10};
    logic [31:0] op_in   [3] = '{32'h00FF7F80, 32'h7F80FF00, 32'hF5000FF0};
    logic [31:0] op_exp  [3] = '{32'hFF00807F, 32'h00FFFF00, 32'hFF101FFF};
    for (int i = 0; i < 3; i++) begin
      do_reset();
      mode = op_mode[i]; param = op_par[i]; in_data = op_in[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== op_exp[i]) begin
        miscompares++;
        $display("FAIL op_mode%0d got valid=%0b data=%h want valid=1 data=%h", op_mode[i], out_valid, out_data, op_exp[i]);
      end
    end
    mode = 2'd0; param = '0;
  endtask

  task automatic test_frame_latch();
    logic [31:0] got_d [8];
    logic        got_l [8];
    logic [31:0] exp_d;
    int got = 0;
    do_reset();
    for (int k = 0; k < 5 + 4; k++) begin
      if (k < 5) begin
        in_valid = 1'b1;
        in_data  = 32'h10203040 + 32'(k) * 32'h01010101;
        mode     = (k == 0) ? 2'd0 : 2'd1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_valid && got < 8) begin got_d[got] = out_data; got_l[got] = out_last; got++; end
    end
    mode = 2'd0;
    vectors++; if (got !== 5) begin miscompares++; $display("FAIL frame_count got %0d want 5", got); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL frame_busy_new got %0b want 1", busy); end
    for (int k = 0; k < 5 && k < got; k++) begin
      exp_d = 32'h10203040 + 32'(k) * 32'h01010101;
      if (k == 4) exp_d = ~exp_d;
      vectors++;
      if (got_d[k] !== exp_d || got_l[k] !== (k == 3)) begin
        miscompares++;
        $display("FAIL frame_word%0d got data=%h last=%0b want data=%h last=%0b", k, got_d[k], got_l[k], exp_d, (k == 3));
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [31:0] got_d [8];
    logic        got_l [8];
    logic [31:0] prev_d;
    logic        prev_l;
    logic        was_hold, acc;
    int idx = 0;
    int got = 0;
    int saw_ustall = 0;
    do_reset();
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      downstream_stall = (cyc >= 3 && cyc < 8);
      in_valid = (idx < 6);
      in_data  = 32'hA0000000 + 32'(idx);
      #1;
      if (upstream_stall) saw_ustall = 1;
      if (out_valid && !downstream_stall && got < 8) begin got_d[got] = out_data; got_l[got] = out_last; got++; end
      acc = in_valid && !upstream_stall;
      was_hold = out_valid && downstream_stall;
      prev_d = out_data; prev_l = out_last;
      tick();
      if (acc) idx++;
      if (was_hold) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l) begin
          miscompares++;
          $display("FAIL stall_hold cyc%0d got valid=%0b data=%h want valid=1 data=%h", cyc, out_valid, out_data, prev_d);
        end
      end
    end
    in_valid = 1'b0; downstream_stall = 1'b0;
    vectors++; if (saw_ustall !== 1) begin miscompares++; $display("FAIL stall_upstream got %0d want 1", saw_ustall); end
    vectors++; if (got !== 6) begin miscompares++; $display("FAIL stall_count got %0d want 6", got); end
    for (int k = 0; k < got && k < 6; k++) begin
      vectors++;
      if (got_d[k] !== 32'hA0000000 + 32'(k) || got_l[k] !== (k == 3)) begin
        miscompares++;
        $display("FAIL stall_word%0d got data=%h last=%0b want data=%h last=%0b", k, got_d[k], got_l[k], 32'hA0000000 + 32'(k), (k == 3));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int got = 0;
    int last_at = -1;
    int last_cnt = 0;
    do_reset();
    in_valid = 1'b1; in_data = 32'h01020304;
    tick();
    in_data = 32'h05060708;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_valid got %0b want 1", out_valid); end
    reset = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid got %0b want 0", out_valid); end
    vectors++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL rstmid_data got %h want 00000000", out_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %0b want 0", busy); end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = (k < 4);
      in_data  = 32'hC0000000 + 32'(k);
      tick();
      if (out_valid) begin
        got++;
        if (out_last) begin last_at = got; last_cnt++; end
      end
    end
    in_valid = 1'b0;
    vectors++; if (got !== 4) begin miscompares++; $display("FAIL rstmid_count got %0d want 4", got); end
    vectors++;
    if (last_at !== 4 || last_cnt !== 1) begin
      miscompares++;
      $display("FAIL rstmid_last got pos=%0d n=%0d want pos=4 n=1", last_at, last_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_pass_latency();
    test_ops();
    test_frame_latch();
    test_back_to_back_stall();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/img_preproc_stream.md
IMG_PREPROC_STREAM -- requirements
Module: img_preproc_stream

Interface
REQ-001 Parameter PIX_W, default 8, meaning bits per pixel lane (unsigned).
REQ-002 Parameter LANES, default 4, meaning pixels packed per stream word; derived DATA_W = PIX_W*LANES; lane i = bits [i*PIX_W +: PIX_W].
REQ-003 Parameter FRAME_WORDS, default 16, meaning words per frame (>=2); counter width $clog2(FRAME_WORDS).
REQ-004 Port clock  input  1  single clock; all state on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port in_data  input  DATA_W  packed input pixels.
REQ-007 Port in_valid  input  1  in_data valid this cycle.
REQ-008 Port upstream_stall  output  1  block cannot accept; a word transfers when in_valid && !upstream_stall.
REQ-009 Port mode  input  2  op select: 0 PASS, 1 INVERT, 2 THRESH, 3 ADD_SAT.
REQ-010 Port param  input  PIX_W  threshold (THRESH) or offset (ADD_SAT).
REQ-011 Port out_data  output  DATA_W  processed pixels.
REQ-012 Port out_valid  output  1  out_data valid.
REQ-013 Port out_last  output  1  out_data is final word of a frame; meaningful only with out_valid.
REQ-014 Port downstream_stall  input  1  consumer not ready; output holds while out_valid && downstream_stall.
REQ-015 Port busy  output  1  high while a frame is partially accepted (FSM in ACTIVE).

Function
REQ-016 Pipeline SHALL have two registered stages (S1 compute, S2 output); latency in-accept to out_valid = 2 cycles with no stall.
REQ-017 Stage enables: s2_en = !out_valid || !downstream_stall; s1_en = !s1_valid || s2_en; upstream_stall = !s1_en, no combinational path from in_valid to upstream_stall.
REQ-018 Full throughput: one word per cycle when downstream_stall low; no word dropped or duplicated under any stall pattern; order preserved.
REQ-019 While stalled, out_data/out_valid/out_last and S1 contents SHALL hold unchanged.
REQ-020 Per-lane ops: PASS p; INVERT (2^PIX_W-1)-p; THRESH (p >= param) ? all-ones : 0; ADD_SAT min(p+param, 2^PIX_W-1) computed at PIX_W+1 bits.
REQ-021 FSM states IDLE, ACTIVE; reset to IDLE.
REQ-022 IDLE: on accepted word, latch mode and param into frame registers, word_cnt <= 1, go ACTIVE; that word uses the newly latched values.
REQ-023 ACTIVE: each accepted word uses latched mode/param (mode/param changes mid-frame ignored), word_cnt increments.
REQ-024 Word accepted with word_cnt == FRAME_WORDS-1 SHALL be tagged last, clear word_cnt, return to IDLE; next accepted word starts new frame.
REQ-025 Last tag travels with its word through S1/S2 and appears as out_last with out_valid.
REQ-026 Cycles without acceptance SHALL not change FSM or word_cnt.

Reset
REQ-027 Reset asserted: out_data=0, out_valid=0, out_last=0, S1 valid/data=0, word_cnt=0, FSM IDLE, busy=0, latched mode/param=0, immediately (asynchronously).
REQ-028 Reset mid-frame SHALL discard in-flight words and partial frame; first word after release starts a new frame.

Structure
REQ-029 Package img_preproc_pkg SHALL hold mode enum typedef (PASS/INVERT/THRESH/ADD_SAT), FSM state typedef, and mode width constant.
REQ-030 Per-lane operation SHALL be combinational sub-module img_preproc_lane (PIX_W parameter), instantiated LANES times via generate.

Verification (PIX_W=8, LANES=4, FRAME_WORDS=4)
REQ-031 PASS, in 0x11223344 at cycle t, no stall -> out_data 0x11223344, out_valid high at t+2 for one cycle.
REQ-032 INVERT, in 0x00FF7F80 -> 0xFF00807F; THRESH param 0x80, in 0x7F80FF00 -> 0x00FFFF00; ADD_SAT param 0x10, in 0xF5000FF0 -> 0xFF101FFF.
REQ-033 Word 0 with PASS, mode switched to INVERT for words 1-3 -> words 0-3 unchanged, out_last on word 3 only; word 4 inverted.
REQ-034 Stream 6 words, downstream_stall high 5 cycles mid-stream -> upstream_stall high once S1 and S2 both hold, output held stable, all 6 words delivered once in order.
REQ-035 Reset asserted after 2 words of a frame -> outputs 0 same cycle, busy 0; after release 4 new words -> out_last on 4th.
